// File: rtl/p_uart_pkt_loop_if.sv
//------------------------------------------------------------------------------
// Module   : p_uart_pkt_loop_if
// Brief    : Signal bundle between the packet loop engine and its receive /
//            send neighbours. The master side is the loop engine itself.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface p_uart_pkt_loop_if #(
    parameter int PKT_BYTES  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DROP_CNT_W = 8
);
    localparam int DW = 8 * PKT_BYTES;
    localparam int AW = $clog2(FIFO_DEPTH);

    logic                  recv_done;
    logic [DW-1:0]         recv_data;
    logic                  tx_busy;
    logic                  send_en;
    logic [DW-1:0]         send_data;
    logic [AW:0]           fifo_level;
    logic                  overflow;
    logic [DROP_CNT_W-1:0] drop_cnt;

    // Loop engine view
    modport master (
        input  recv_done,
        input  recv_data,
        input  tx_busy,
        output send_en,
        output send_data,
        output fifo_level,
        output overflow,
        output drop_cnt
    );

    // Environment view (receiver, sender, status observer)
    modport slave (
        output recv_done,
        output recv_data,
        output tx_busy,
        input  send_en,
        input  send_data,
        input  fifo_level,
        input  overflow,
        input  drop_cnt
    );
endinterface

`default_nettype wire

// File: rtl/p_uart_pkt_loop.sv
//------------------------------------------------------------------------------
// Module   : p_uart_pkt_loop
// Brief    : Packet loop engine. Buffers received packets in a packet FIFO,
//            replays them one per sender handshake, counts overflow drops.
//            Optional checksum mode: define UART_LOOP_CKSUM_EN to replace the
//            last byte of each sent packet with the XOR of the other bytes.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module p_uart_pkt_loop #(
    parameter int PKT_BYTES  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DROP_CNT_W = 8,
    parameter int BUSY_WAIT  = 4
) (
    input  wire logic             sys_clk,
    input  wire logic             sys_rst_n,
    p_uart_pkt_loop_if.master     bus
);
    localparam int DW = 8 * PKT_BYTES;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(BUSY_WAIT + 1);

    localparam logic [AW:0]   c_FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] c_WAIT_LAST  = CW'(BUSY_WAIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [DW-1:0]         r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [AW:0]           r_level;
    logic [CW-1:0]         r_wait_cnt;
    logic                  r_send_en;
    logic [DW-1:0]         r_send_data;
    logic                  r_overflow;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [DW-1:0]         w_head_raw;
    logic [DW-1:0]         w_head_data;

    // Occupancy comes from the level count so full and empty are unambiguous
    // with equal pointers.
    assign w_full  = (r_level == c_FULL_LEVEL);
    assign w_empty = (r_level == '0);

    // A pop only happens from IDLE with an idle sender; a push into a full
    // FIFO is still accepted when a pop frees the slot in the same cycle.
    assign w_pop  = (r_state == ST_IDLE) && !w_empty && !bus.tx_busy;
    assign w_push = bus.recv_done && (!w_full || w_pop);
    assign w_drop = bus.recv_done && w_full && !w_pop;

    assign w_head_raw = r_mem[r_rptr];

`ifdef UART_LOOP_CKSUM_EN
    logic [7:0] w_cksum;

    // Checksum byte replaces the top byte of the head packet at pop time
    always_comb begin
        w_cksum = 8'h00;
        for (int b = 0; b < PKT_BYTES - 1; b++) begin
            w_cksum = w_cksum ^ w_head_raw[8*b +: 8];
        end
        w_head_data = {w_cksum, w_head_raw[DW-9:0]};
    end
`else
    assign w_head_data = w_head_raw;
`endif

    // Packet storage; contents need no reset because the level gates reads
    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.recv_data;
        end
    end

    // FIFO pointers, level and drop accounting
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            r_overflow <= w_drop;
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    // Send handshake FSM with registered start pulse and packet
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= ST_IDLE;
            r_wait_cnt  <= '0;
            r_send_en   <= 1'b0;
            r_send_data <= '0;
        end else begin
            r_send_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_send_data <= w_head_data;
                        r_send_en   <= 1'b1;
                        r_wait_cnt  <= '0;
                        r_state     <= ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_BUSY: begin
                    // A sender that never answers must not stall the loop;
                    // the packet is treated as sent.
                    if (bus.tx_busy) begin
                        r_state <= ST_WAIT_DONE;
                    end else if (r_wait_cnt == c_WAIT_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.send_en    = r_send_en;
    assign bus.send_data  = r_send_data;
    assign bus.fifo_level = r_level;
    assign bus.overflow   = r_overflow;
    assign bus.drop_cnt   = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_p_uart_pkt_loop.sv
//------------------------------------------------------------------------------
// Module   : tb_p_uart_pkt_loop
// Brief    : Scoreboard bench for p_uart_pkt_loop. Stimulus pushes expected
//            packets into a queue; a monitor pops and compares on send_en.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_p_uart_pkt_loop;
    localparam int PKT_BYTES  = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int DROP_CNT_W = 8;
    localparam int BUSY_WAIT  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    p_uart_pkt_loop_if #(
        .PKT_BYTES (PKT_BYTES),
        .FIFO_DEPTH(FIFO_DEPTH),
        .DROP_CNT_W(DROP_CNT_W)
    ) bus ();

    p_uart_pkt_loop #(
        .PKT_BYTES (PKT_BYTES),
        .FIFO_DEPTH(FIFO_DEPTH),
        .DROP_CNT_W(DROP_CNT_W),
        .BUSY_WAIT (BUSY_WAIT)
    ) dut (
        .sys_clk  (clk),
        .sys_rst_n(rst_n),
        .bus      (bus)
    );

    int          tests   = 0;
    int          fails   = 0;
    int          sends   = 0;
    int          ovf_cnt = 0;
    int          cyc     = 0;
    int          send_cyc[$];
    logic [63:0] exp_q[$];

    // Sender model: tx_busy rises one cycle after send_en, stays high busy_len
    // cycles; busy_len == 0 models a sender that never answers.
    int   busy_len   = 100;
    logic model_busy = 1'b0;
    logic busy_stuck = 1'b0;
    assign bus.tx_busy = model_busy | busy_stuck;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] expect_of(input logic [63:0] d);
`ifdef UART_LOOP_CKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        for (int b = 0; b < 7; b++) x = x ^ d[8*b +: 8];
        return {x, d[55:0]};
`else
        return d;
`endif
    endfunction

    function automatic logic [63:0] pk(input int tag, input int i);
        return {32'hC0DE_0000 + 32'(tag), 32'h1000_0000 + 32'(i)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // n back-to-back recv_done pulses; the first n_exp are expected to be sent
    task automatic burst(input int tag, input int n, input int n_exp);
        tick;
        for (int i = 0; i < n; i++) begin
            bus.recv_done = 1'b1;
            bus.recv_data = pk(tag, i);
            if (i < n_exp) exp_q.push_back(expect_of(pk(tag, i)));
            tick;
        end
        bus.recv_done = 1'b0;
    endtask

    task automatic wait_sends(input string name, input int target, input int budget);
        int k;
        k = 0;
        while (sends < target && k < budget) begin
            tick;
            k++;
        end
        check(name, 64'(sends), 64'(target));
    endtask

    task automatic wait_model_idle;
        int k;
        k = 0;
        while (model_busy && k < 500) begin
            tick;
            k++;
        end
    endtask

    // Sender model process
    initial begin
        forever begin
            @(negedge clk);
            if (bus.send_en && busy_len > 0) begin
                @(posedge clk);
                #1 model_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 model_busy = 1'b0;
            end
        end
    end

    // Monitor: every send_en pops one expected packet
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (bus.overflow) ovf_cnt++;
            if (bus.send_en) begin
                sends++;
                send_cyc.push_back(cyc);
                tests++;
                if (bus.tx_busy) begin
                    fails++;
                    $display("FAIL send_while_busy: got tx_busy=1, expected 0");
                end
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_send: got %h, expected no send", bus.send_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.send_data !== e) begin
                        fails++;
                        $display("FAIL send_data: got %h, expected %h", bus.send_data, e);
                    end
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int o;
        logic [DROP_CNT_W-1:0] d0;

        bus.recv_done = 1'b0;
        bus.recv_data = '0;

        // Reset state
        repeat (3) tick;
        check("rst_send_en",   64'(bus.send_en),    64'h0);
        check("rst_send_data", bus.send_data,       64'h0);
        check("rst_level",     64'(bus.fifo_level), 64'h0);
        check("rst_overflow",  64'(bus.overflow),   64'h0);
        check("rst_drop_cnt",  64'(bus.drop_cnt),   64'h0);
        rst_n = 1'b1;
        tick;

        // 1: reset in the middle of a launch; both stored packets are lost
        tick;
        bus.recv_done = 1'b1;
        bus.recv_data = 64'h1111_1111_1111_1111;
        tick;
        bus.recv_data = 64'h2222_2222_2222_2222;
        tick;
        bus.recv_done = 1'b0;
        check("t1_launch", 64'(bus.send_en), 64'h1);
        rst_n = 1'b0;
        #1;
        check("t1_async_send_en", 64'(bus.send_en),    64'h0);
        check("t1_async_level",   64'(bus.fifo_level), 64'h0);
        repeat (3) tick;
        rst_n = 1'b1;
        s = sends;
        repeat (20) tick;
        check("t1_no_send",   64'(sends),          64'(s));
        check("t1_send_data", bus.send_data,       64'h0);
        check("t1_level",     64'(bus.fifo_level), 64'h0);
        check("t1_drop_cnt",  64'(bus.drop_cnt),   64'h0);

        // 2: single packet with a 100-cycle sender
        busy_len = 100;
        s = sends;
        tick;
        bus.recv_done = 1'b1;
        bus.recv_data = 64'h0807060504030201;
        exp_q.push_back(expect_of(64'h0807060504030201));
        tick;
        bus.recv_done = 1'b0;
        check("t2_level_1", 64'(bus.fifo_level), 64'h1);
        wait_sends("t2_sent", s + 1, 10);
        check("t2_level_0", 64'(bus.fifo_level), 64'h0);
        wait_model_idle;
        repeat (5) tick;
        check("t2_one_send", 64'(sends), 64'(s + 1));

        // 3: six pushes with the sender stuck busy; two are dropped
        busy_len   = 3;
        busy_stuck = 1'b1;
        s = sends;
        o = ovf_cnt;
        burst(3, 6, 4);
        repeat (2) tick;
        check("t3_level_full", 64'(bus.fifo_level), 64'h4);
        check("t3_drop_cnt",   64'(bus.drop_cnt),   64'h2);
        check("t3_ovf_pulses", 64'(ovf_cnt - o),    64'h2);
        busy_stuck = 1'b0;
        wait_sends("t3_drain", s + 4, 200);
        repeat (6) tick;
        check("t3_level_0", 64'(bus.fifo_level), 64'h0);

        // 4: sender never answers; timeout then the next packet launches
        wait_model_idle;
        busy_len = 0;
        s = sends;
        burst(4, 2, 2);
        wait_sends("t4_sent", s + 2, 50);
        check("t4_gap", 64'(send_cyc[s + 1] - send_cyc[s]), 64'(BUSY_WAIT + 1));
        repeat (20) tick;
        check("t4_no_resend", 64'(sends),          64'(s + 2));
        check("t4_level_0",   64'(bus.fifo_level), 64'h0);

        // 5: full FIFO, push coincident with pop
        busy_len   = 3;
        busy_stuck = 1'b1;
        s  = sends;
        o  = ovf_cnt;
        d0 = bus.drop_cnt;
        burst(5, 4, 4);
        check("t5_level_full", 64'(bus.fifo_level), 64'h4);
        busy_stuck    = 1'b0;
        bus.recv_done = 1'b1;
        bus.recv_data = 64'hEEEE_5555_0000_0005;
        exp_q.push_back(expect_of(64'hEEEE_5555_0000_0005));
        tick;
        bus.recv_done = 1'b0;
        check("t5_level_kept", 64'(bus.fifo_level), 64'h4);
        check("t5_no_overflow", 64'(bus.overflow),  64'h0);
        check("t5_drop_same",  64'(bus.drop_cnt),   64'(d0));
        wait_sends("t5_drain", s + 5, 200);
        check("t5_no_ovf_pulse", 64'(ovf_cnt - o), 64'h0);

        // 6: checksum byte; XOR of bytes 01..07 is 8'h00
        wait_model_idle;
        s = sends;
`ifdef UART_LOOP_CKSUM_EN
        exp_q.push_back(64'h0007060504030201);
`else
        exp_q.push_back(64'hFF07060504030201);
`endif
        tick;
        bus.recv_done = 1'b1;
        bus.recv_data = 64'hFF07060504030201;
        tick;
        bus.recv_done = 1'b0;
        wait_sends("t6_sent", s + 1, 20);

        // 7: drop counter saturates at all-ones
        wait_model_idle;
        repeat (2) tick;
        busy_stuck = 1'b1;
        s = sends;
        burst(7, 4 + 300, 4);
        tick;
        check("t7_drop_sat", 64'(bus.drop_cnt), 64'hFF);
        busy_stuck = 1'b0;
        wait_sends("t7_drain", s + 4, 200);
        wait_model_idle;
        repeat (4) tick;
        check("t7_level_0",     64'(bus.fifo_level), 64'h0);
        check("end_queue_empty", 64'(exp_q.size()),  64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
